// File: rtl/tx_stream_arbiter.sv
// Round-robin packet arbiter merging NUM_SRC AXI-stream sources onto one output.
// Over-long packets get a forced tlast; their remaining source beats are discarded.
module tx_stream_arbiter #(
   parameter int NUM_SRC              = 4,
   parameter int WORD_BYTES           = 1,
   parameter int PACKET_PAYLOAD_WORDS = 128
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_SRC*WORD_BYTES*8-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]              s_axis_tvalid,
   input  logic [NUM_SRC-1:0]              s_axis_tlast,
   output logic [NUM_SRC-1:0]              s_axis_tready,
   output logic [WORD_BYTES*8-1:0]         m_axis_tdata,
   output logic                            m_axis_tvalid,
   output logic                            m_axis_tlast,
   input  logic                            m_axis_tready,
   output logic [NUM_SRC-1:0]              grant,
   output logic [15:0]                     trunc_count
);
   localparam int DW = WORD_BYTES * 8;
   localparam int IW = $clog2(NUM_SRC);
   localparam int CW = $clog2(PACKET_PAYLOAD_WORDS + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SRC - 1);
   localparam logic [CW-1:0] MAX_BEAT = CW'(PACKET_PAYLOAD_WORDS - 1);

   typedef enum logic [1:0] {IDLE, FORWARD, DROP} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [IW-1:0]      r_grant_idx;
   logic [IW-1:0]      r_last_grant;
   logic [NUM_SRC-1:0] r_grant;
   logic [CW-1:0]      r_beat_cnt;
   logic [15:0]        r_trunc_count;
   logic [IW-1:0]      w_arb_idx;
   logic [IW-1:0]      w_cand;
   logic               w_arb_found;
   logic               w_src_valid;
   logic               w_src_last;
   logic               w_cnt_max;
   logic               w_m_hs;
   logic [DW-1:0]      w_src_data [NUM_SRC];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_slice
         assign w_src_data[gi] = s_axis_tdata[gi*DW +: DW];
      end
   endgenerate

   assign w_src_valid   = s_axis_tvalid[r_grant_idx];
   assign w_src_last    = s_axis_tlast[r_grant_idx];
   assign w_cnt_max     = (r_beat_cnt == MAX_BEAT);
   assign w_m_hs        = (r_state == FORWARD) && w_src_valid && m_axis_tready;
   assign m_axis_tdata  = w_src_data[r_grant_idx];
   assign grant         = r_grant;
   assign trunc_count   = r_trunc_count;

   // Scan starts just after the previous owner, so it gets lowest priority.
   always_comb begin
      w_arb_found = 1'b0;
      w_arb_idx   = '0;
      w_cand      = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         w_cand = IW'((int'(r_last_grant) + k) % NUM_SRC);
         if (!w_arb_found && s_axis_tvalid[w_cand]) begin
            w_arb_found = 1'b1;
            w_arb_idx   = w_cand;
         end
      end
   end

   always_comb begin
      w_state_next  = r_state;
      s_axis_tready = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_arb_found) w_state_next = FORWARD;
         end
         FORWARD: begin
            m_axis_tvalid              = w_src_valid;
            m_axis_tlast               = w_src_last | w_cnt_max;
            s_axis_tready[r_grant_idx] = m_axis_tready;
            if (w_m_hs && m_axis_tlast) w_state_next = w_src_last ? IDLE : DROP;
         end
         DROP: begin
            s_axis_tready[r_grant_idx] = 1'b1;
            if (w_src_valid && w_src_last) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
      // Nothing may handshake while reset is held, even before the registers clear.
      if (rst) begin
         s_axis_tready = '0;
         m_axis_tvalid = 1'b0;
         m_axis_tlast  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_grant       <= '0;
         r_grant_idx   <= '0;
         r_last_grant  <= LAST_IDX;
         r_beat_cnt    <= '0;
         r_trunc_count <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == IDLE && w_arb_found) begin
            r_grant_idx  <= w_arb_idx;
            r_last_grant <= w_arb_idx;
            r_grant      <= NUM_SRC'(1) << w_arb_idx;
         end
         if (w_m_hs) r_beat_cnt <= r_beat_cnt + CW'(1);
         if (r_state != IDLE && w_state_next == IDLE) begin
            r_grant    <= '0;
            r_beat_cnt <= '0;
         end
         if (r_state == FORWARD && w_state_next == DROP && r_trunc_count != 16'hFFFF)
            r_trunc_count <= r_trunc_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Bench for tx_stream_arbiter: arbitration vector table, packet-level scoreboard
// with randomized sources/backpressure, reset-mid-packet and saturation sequences.
module tb_tx_stream_arbiter;
   localparam int NS  = 4;
   localparam int PPW = 128;

   logic            clk = 1'b0;
   logic            rst;
   logic [NS*8-1:0] s_tdata;
   logic [NS-1:0]   s_tvalid;
   logic [NS-1:0]   s_tlast;
   logic [NS-1:0]   s_tready;
   logic [7:0]      m_tdata;
   logic            m_tvalid;
   logic            m_tlast;
   logic            m_tready;
   logic [NS-1:0]   grant;
   logic [15:0]     trunc_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tx_stream_arbiter #(
      .NUM_SRC(NS), .WORD_BYTES(1), .PACKET_PAYLOAD_WORDS(PPW)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
      .m_axis_tready(m_tready),
      .grant(grant), .trunc_count(trunc_count)
   );

   // Source packets queued per source, the expected merged stream, and what was seen.
   logic [7:0]    sq_data [NS][$];
   bit            sq_last [NS][$];
   int            sq_len  [NS][$];
   logic [7:0]    ex_data[$];
   bit            ex_last[$];
   int            ex_src[$];
   logic [7:0]    cap_data[$];
   bit            cap_last[$];
   logic [NS-1:0] cap_grant[$];
   int            m_last;
   logic [15:0]   exp_trunc;

   typedef struct {
      logic [NS-1:0] mask;
      logic [NS-1:0] exp_grant;
      logic [7:0]    exp_data;
   } vec_t;
   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_packet(input int src, input int len);
      for (int b = 0; b < len; b++) begin
         sq_data[src].push_back(8'($urandom));
         sq_last[src].push_back(b == len - 1);
      end
      sq_len[src].push_back(len);
   endtask

   // Packet-level model: every source with a pending packet is valid when the
   // arbiter is idle, so owners follow round-robin over non-empty queues.
   task automatic build_expect();
      int pk[NS];
      int off[NS];
      int s, c, len, n;
      for (int i = 0; i < NS; i++) begin
         pk[i]  = 0;
         off[i] = 0;
      end
      ex_data.delete();
      ex_last.delete();
      ex_src.delete();
      forever begin
         s = -1;
         for (int k = 1; k <= NS; k++) begin
            c = (m_last + k) % NS;
            if (s < 0 && pk[c] < sq_len[c].size()) s = c;
         end
         if (s < 0) break;
         len = sq_len[s][pk[s]];
         n   = (len > PPW) ? PPW : len;
         for (int b = 0; b < n; b++) begin
            ex_data.push_back(sq_data[s][off[s] + b]);
            ex_last.push_back(b == n - 1);
            ex_src.push_back(s);
         end
         if (len > PPW && exp_trunc != 16'hFFFF) exp_trunc = exp_trunc + 16'd1;
         off[s] += len;
         pk[s]++;
         m_last = s;
      end
   endtask

   // Entered at posedge+1 with the DUT idle.
   task automatic run_scenario(input string name, input int ready_pct, input int gap_pct);
      int ptr[NS];
      bit hs[NS];
      bit first, all_done, done;
      int idle_run, inv_bad, n;
      build_expect();
      cap_data.delete();
      cap_last.delete();
      cap_grant.delete();
      for (int i = 0; i < NS; i++) ptr[i] = 0;
      inv_bad  = 0;
      idle_run = 0;
      done     = 1'b0;
      for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
         for (int i = 0; i < NS; i++) begin
            if (ptr[i] < sq_data[i].size()) begin
               first = (ptr[i] == 0) || sq_last[i][ptr[i] - 1];
               s_tvalid[i]      = first || ($urandom_range(99) >= gap_pct);
               s_tdata[i*8 +: 8] = sq_data[i][ptr[i]];
               s_tlast[i]       = sq_last[i][ptr[i]];
            end else begin
               s_tvalid[i]      = 1'b0;
               s_tdata[i*8 +: 8] = 8'($urandom);
               s_tlast[i]       = 1'b0;
            end
         end
         m_tready = ($urandom_range(99) < ready_pct);
         @(negedge clk);
         for (int i = 0; i < NS; i++) hs[i] = s_tvalid[i] && s_tready[i];
         if (m_tvalid && m_tready) begin
            cap_data.push_back(m_tdata);
            cap_last.push_back(m_tlast);
            cap_grant.push_back(grant);
         end
         if (!$onehot0(grant) || ((s_tready & ~grant) != '0)) inv_bad++;
         @(posedge clk);
         #1;
         all_done = 1'b1;
         for (int i = 0; i < NS; i++) begin
            if (hs[i]) ptr[i]++;
            if (ptr[i] < sq_data[i].size()) all_done = 1'b0;
         end
         if (all_done) idle_run++;
         if (idle_run >= 3) done = 1'b1;
      end
      check($sformatf("%s completed", name), 32'(done), 32'd1);
      check($sformatf("%s beat count", name), cap_data.size(), ex_data.size());
      n = (cap_data.size() < ex_data.size()) ? cap_data.size() : ex_data.size();
      for (int j = 0; j < n; j++) begin
         check($sformatf("%s beat%0d data", name, j), 32'(cap_data[j]), 32'(ex_data[j]));
         check($sformatf("%s beat%0d tlast", name, j), 32'(cap_last[j]), 32'(ex_last[j]));
         check($sformatf("%s beat%0d grant", name, j), 32'(cap_grant[j]), 32'(1) << ex_src[j]);
      end
      check($sformatf("%s trunc_count", name), 32'(trunc_count), 32'(exp_trunc));
      check($sformatf("%s tready/grant invariants", name), inv_bad, 0);
      for (int i = 0; i < NS; i++) begin
         sq_data[i].delete();
         sq_last[i].delete();
         sq_len[i].delete();
      end
      s_tvalid = '0;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      s_tvalid = '1;
      s_tlast  = '0;
      m_tready = 1'b1;
      @(negedge clk);
      check("reset s_tready", 32'(s_tready), 32'd0);
      check("reset m_tvalid", 32'(m_tvalid), 32'd0);
      check("reset m_tlast", 32'(m_tlast), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("reset grant", 32'(grant), 32'd0);
      check("reset trunc_count", 32'(trunc_count), 32'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      s_tvalid  = '0;
      m_last    = NS - 1;
      exp_trunc = 16'd0;
   endtask

   initial begin
      int src, len;
      vecs[0]  = '{4'b0101, 4'b0001, 8'hA0};
      vecs[1]  = '{4'b0101, 4'b0100, 8'hA2};
      vecs[2]  = '{4'b0101, 4'b0001, 8'hA0};
      vecs[3]  = '{4'b1111, 4'b0010, 8'hA1};
      vecs[4]  = '{4'b0001, 4'b0001, 8'hA0};
      vecs[5]  = '{4'b1000, 4'b1000, 8'hA3};
      vecs[6]  = '{4'b1001, 4'b0001, 8'hA0};
      vecs[7]  = '{4'b1001, 4'b1000, 8'hA3};
      vecs[8]  = '{4'b0110, 4'b0010, 8'hA1};
      vecs[9]  = '{4'b0110, 4'b0100, 8'hA2};
      vecs[10] = '{4'b1011, 4'b1000, 8'hA3};
      vecs[11] = '{4'b1011, 4'b0001, 8'hA0};

      s_tdata = '0;
      do_reset();

      // Single-beat packets: one arbitration per vector, owner chain from reset.
      s_tlast  = '1;
      m_tready = 1'b1;
      for (int i = 0; i < NS; i++) s_tdata[i*8 +: 8] = 8'hA0 + 8'(i);
      for (int v = 0; v < 12; v++) begin
         s_tvalid = vecs[v].mask;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d grant", v), 32'(grant), 32'(vecs[v].exp_grant));
         check($sformatf("vec%0d s_tready", v), 32'(s_tready), 32'(vecs[v].exp_grant));
         check($sformatf("vec%0d m_tvalid", v), 32'(m_tvalid), 32'd1);
         check($sformatf("vec%0d m_tlast", v), 32'(m_tlast), 32'd1);
         check($sformatf("vec%0d m_tdata", v), 32'(m_tdata), 32'(vecs[v].exp_data));
         @(posedge clk);
         #1;
      end
      s_tvalid = '0;
      s_tlast  = '0;

      do_reset();
      add_packet(0, 4);
      add_packet(2, 4);
      run_scenario("two_src", 100, 0);

      for (int p = 0; p < 3; p++)
         for (int i = 0; i < NS; i++) add_packet(i, $urandom_range(6, 1));
      run_scenario("all_src", 100, 0);

      add_packet(1, 130);
      add_packet(1, 128);
      add_packet(3, 2);
      run_scenario("long_pkt", 80, 20);

      // Reset on beat 5 of a 10-beat packet from source 0.
      s_tvalid          = 4'b0001;
      s_tlast           = '0;
      m_tready          = 1'b1;
      s_tdata[7:0]      = 8'h50;
      @(posedge clk);
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         check($sformatf("midrst beat%0d data", b), 32'(m_tdata), 32'h50 + 32'(b));
         check($sformatf("midrst beat%0d valid", b), 32'(m_tvalid), 32'd1);
         @(posedge clk);
         #1;
         s_tdata[7:0] = 8'h51 + 8'(b);
      end
      rst = 1'b1;
      @(negedge clk);
      check("midrst s_tready in reset", 32'(s_tready), 32'd0);
      check("midrst m_tvalid in reset", 32'(m_tvalid), 32'd0);
      check("midrst m_tlast in reset", 32'(m_tlast), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("midrst grant", 32'(grant), 32'd0);
      check("midrst trunc_count", 32'(trunc_count), 32'd0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      s_tvalid = 4'b0011;
      @(negedge clk);
      check("midrst idle m_tvalid", 32'(m_tvalid), 32'd0);
      check("midrst idle s_tready", 32'(s_tready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("midrst rearb grant", 32'(grant), 32'b0001);
      @(posedge clk);
      #1;
      do_reset();

      for (int p = 0; p < 16; p++) begin
         src = $urandom_range(NS - 1);
         len = ($urandom_range(7) == 0) ? $urandom_range(135, 125) : $urandom_range(20, 1);
         add_packet(src, len);
      end
      run_scenario("random", 60, 30);

      // Skip 65534 truncations by loading the counter, then truncate twice more.
      force dut.r_trunc_count = 16'hFFFE;
      @(posedge clk);
      #1;
      release dut.r_trunc_count;
      exp_trunc = 16'hFFFE;
      add_packet(2, 130);
      add_packet(3, 129);
      add_packet(0, 3);
      run_scenario("saturate", 90, 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tx_stream_arbiter.md
TX_STREAM_ARBITER -- requirements
Module: tx_stream_arbiter

Interface
REQ-001 The block SHALL take parameter NUM_SRC, default 4, as the number of AXI-stream sources (2..8).
REQ-002 The block SHALL take parameter WORD_BYTES, default 1, as the bytes per beat.
REQ-003 The block SHALL take parameter PACKET_PAYLOAD_WORDS, default 128, as the maximum beats per packet.
REQ-004 The block SHALL have port clk, input, 1 bit, the clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have port s_axis_tdata, input, NUM_SRC*WORD_BYTES*8 bits; source i occupies slice i.
REQ-007 The block SHALL have ports s_axis_tvalid, input, and s_axis_tlast, input, each NUM_SRC bits, one bit per source.
REQ-008 The block SHALL have port s_axis_tready, output, NUM_SRC bits, one bit per source.
REQ-009 The block SHALL have ports m_axis_tdata (WORD_BYTES*8), m_axis_tvalid, m_axis_tlast (outputs) and m_axis_tready (input), the merged stream to the packet transmitter.
REQ-010 The block SHALL have port grant, output, NUM_SRC bits, one-hot current owner or all-zero.
REQ-011 The block SHALL have port trunc_count, output, 16 bits, a saturating count of truncated packets.

Function
REQ-012 The FSM SHALL have states IDLE, FORWARD and DROP.
REQ-013 IDLE: grant=0; all s_axis_tready=0; m_axis_tvalid=0.
REQ-014 IDLE: if any s_axis_tvalid=1, the block SHALL select the first valid source in round-robin order, starting at index (last_grant+1) mod NUM_SRC, then register grant and go to FORWARD next cycle (1-cycle arbitration latency).
REQ-015 last_grant SHALL update only on a grant; its reset value is NUM_SRC-1, so source 0 has first priority after reset.
REQ-016 FORWARD SHALL pass the stream through combinationally (zero latency):
- m_axis_tdata = slice[g]; m_axis_tvalid = s_axis_tvalid[g];
- s_axis_tready[g] = m_axis_tready; all other tready = 0.
REQ-017 A beat counter SHALL increment on each m_axis handshake in FORWARD and clear on entry to IDLE.
REQ-018 m_axis_tlast SHALL be s_axis_tlast[g] OR (beat counter == PACKET_PAYLOAD_WORDS-1).
REQ-019 FORWARD exit on an m_axis handshake with m_axis_tlast=1:
- if s_axis_tlast[g]=1, go to IDLE;
- otherwise (forced tlast), go to DROP and increment trunc_count, saturating at 16'hFFFF.
REQ-020 DROP: s_axis_tready[g]=1 and m_axis_tvalid=0; source beats SHALL be discarded until a handshake with s_axis_tlast[g]=1, then the block SHALL go to IDLE.
REQ-021 grant SHALL stay constant from entry to FORWARD until return to IDLE; no other source SHALL receive tready while granted.
REQ-022 Deassertion of s_axis_tvalid[g] mid-packet SHALL NOT release the grant; the block SHALL wait in FORWARD.
REQ-023 A source asserting tvalid while another is granted SHALL wait, with tready held at 0 and no data loss.
REQ-024 m_axis_tdata SHALL be don't-care when m_axis_tvalid=0.
REQ-025 A source whose valid packet is exactly PACKET_PAYLOAD_WORDS beats, with tlast on the final beat, SHALL go straight to IDLE without DROP or any trunc_count change.

Reset
REQ-026 On rst=1 the block SHALL set state=IDLE, grant=0, beat counter=0, last_grant=NUM_SRC-1 and trunc_count=0.
REQ-027 During rst=1, all s_axis_tready, m_axis_tvalid and m_axis_tlast SHALL be 0.
REQ-028 Reset mid-packet SHALL abandon the packet immediately; no further beats SHALL be forwarded until a new arbitration.

Verification
REQ-029 Sources 0 and 2 both valid after reset, 4-beat packets, m_axis_tready=1 -> source 0 forwarded first, then source 2; grant=0001 then 0100; m_axis_tlast on beat 4 of each.
REQ-030 All 4 sources continuously valid, 3 packets each -> grant order 0,1,2,3,0,1,2,3,... with no source granted twice in a row.
REQ-031 Source 1 sends a 130-beat packet with PACKET_PAYLOAD_WORDS=128 -> output m_axis_tlast on beat 128, beats 129-130 consumed but not forwarded, trunc_count=1.
REQ-032 m_axis_tready toggled randomly and source tvalid gapped mid-packet -> output data order equals input order, no duplicated or lost beats, grant stable for the whole packet.
REQ-033 rst asserted on beat 5 of a 10-beat packet -> next cycle grant=0, all tready=0, trunc_count=0; after release, source 0 wins the next arbitration.
REQ-034 trunc_count preloaded by 65535 truncations, then one more truncated packet -> trunc_count stays 16'hFFFF.
